// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch entry type used by the fetch stage.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;
    localparam logic [ILEN-1:0] NOP          = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push/pop/flush and an occupancy count.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [XLEN-1:0]        push_pc,
    input  logic [ILEN-1:0]        push_instr,
    input  logic                   pop,
    output logic [XLEN-1:0]        head_pc,
    output logic [ILEN-1:0]        head_instr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  slots [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head_pc    = slots[rd_ptr].pc;
    assign head_instr = slots[rd_ptr].instr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= '{pc: push_pc, instr: push_instr};
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A push into a full queue only happens if the caller's credit accounting is broken.
    always_ff @(posedge clock) begin
        if (reset && !flush) begin
            assert (!(push && !pop && count == CW'(DEPTH)));
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues word reads over req/gnt + rvalid and queues
// returned words for the decoder. Define FETCH_ALIGN_CHECK_EN to fault on misaligned redirects.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter int              QDEPTH   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            halt,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [ILEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
`endif
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(QDEPTH);

    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt, target_pc;
    logic [CW-1:0]   outstanding, out_nxt, drop, drop_nxt, occ_nxt;
    logic [CW-1:0]   q_count, pend_count;
    logic            stale, stale_nxt;
    logic            grant, rv, rsp_drop, rsp_keep, q_pop, pend_push;
    logic            fault_nxt, issue_ok;
    logic [XLEN-1:0] pend_pc;
    logic [ILEN-1:0] pend_instr;

    assign grant     = mem_req & mem_gnt;
    assign rv        = mem_rvalid & (outstanding != '0);
    assign rsp_drop  = rv & (drop != '0);
    assign rsp_keep  = rv & (drop == '0) & ~redirect_valid;
    assign q_pop     = instr_valid & instr_ready;
    assign pend_push = grant & ~stale & ~redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign target_pc  = redirect_pc;
    assign fault_nxt  = redirect_valid ? misaligned : fetch_fault;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else if (redirect_valid) begin
            fetch_fault <= misaligned;
            fault_pc    <= misaligned ? redirect_pc : '0;
        end
    end
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign fault_nxt = 1'b0;
`endif

    // A redirect writes off every read already in flight plus an ungranted request,
    // which still completes at its old address ("stale") and is dropped on return.
    always_comb begin
        out_nxt = outstanding + CW'(grant) - CW'(rv);
        occ_nxt = redirect_valid ? '0 : q_count + CW'(rsp_keep) - CW'(q_pop);
        if (redirect_valid) begin
            drop_nxt     = out_nxt;
            stale_nxt    = mem_req & ~mem_gnt;
            fetch_pc_nxt = target_pc;
        end else begin
            drop_nxt     = drop - CW'(rsp_drop) + CW'(grant & stale);
            stale_nxt    = stale & ~grant;
            fetch_pc_nxt = (grant & ~stale) ? next_pc(fetch_pc) : fetch_pc;
        end
        issue_ok = ~halt & ~fault_nxt & (({1'b0, out_nxt} + {1'b0, occ_nxt}) < CREDITS);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            stale       <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            drop        <= drop_nxt;
            stale       <= stale_nxt;
            fetch_pc    <= fetch_pc_nxt;
            if (!(mem_req && !mem_gnt)) begin
                mem_req  <= issue_ok;
                mem_addr <= fetch_pc_nxt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(mem_rvalid && outstanding == '0));
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_pend_q (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (pend_push),
        .push_pc    (mem_addr),
        .push_instr (NOP),
        .pop        (rsp_keep),
        .head_pc    (pend_pc),
        .head_instr (pend_instr),
        .count      (pend_count)
    );

    fetch_queue #(.DEPTH(QDEPTH)) u_instr_q (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (rsp_keep),
        .push_pc    (pend_pc),
        .push_instr (mem_rdata),
        .pop        (q_pop),
        .head_pc    (instr_pc),
        .head_instr (instr_data),
        .count      (q_count)
    );

    assign instr_valid = q_count != '0;

    logic unused_pend;
    assign unused_pend = ^{pend_instr, pend_count};
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random bus/decoder/redirect stimulus checked against
// an in-order PC stream model. Define FETCH_ALIGN_CHECK_EN to exercise the fault ports.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int QDEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        halt = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
    logic [31:0] fault_pc;
`endif

    instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .halt           (halt),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int unsigned cyc = 0;
    logic [31:0] model_pc = RESET_PC;
    logic        dead_pending = 1'b0;
    logic        faulted = 1'b0;

    int          gnt_mode = 0;
    int          rv_pct = 0;
    int          ready_pct = 0;
    int          halt_pct = 0;
    int          redir_pm = 0;
    logic        redir_req = 1'b0;
    logic [31:0] redir_target = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Memory, decoder and execute stand-in: all DUT inputs change 1 time unit after posedge.
    always @(posedge clock) begin
        #1;
        cyc++;
        if (!reset) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            redirect_valid = 1'b0;
            instr_ready = 1'b0;
            halt = 1'b0;
        end else begin
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = ($urandom_range(0, 1) == 1);
                default: mem_gnt = 1'b0;
            endcase
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (mq.size() != 0 && mq[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem_word(mq[0].addr);
            end
            instr_ready = ($urandom_range(0, 99) < ready_pct);
            halt = ($urandom_range(0, 99) < halt_pct);
            redirect_valid = 1'b0;
            if (redir_req) begin
                redirect_valid = 1'b1;
                redirect_pc = redir_target;
                redir_req = 1'b0;
            end else if ($urandom_range(0, 999) < redir_pm) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
                else redirect_pc = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
                redirect_pc[1:0] = 2'b00;
`endif
            end
        end
    end

    // Monitor / reference model: live grants follow the PC stream from the last redirect.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("req_hold", mem_req, 1);
                check("addr_hold", mem_addr, prev_addr);
            end
            if (instr_valid && instr_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h data %h, expected no instruction", instr_pc, instr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr_data", instr_data, e.data);
                end
            end
            if (mem_rvalid && mq.size() != 0) void'(mq.pop_front());
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc & 32'hFFFF_FFFC;
                dead_pending = mem_req && !mem_gnt;
`ifdef FETCH_ALIGN_CHECK_EN
                faulted = (redirect_pc[1:0] != 2'b00);
`endif
            end else if (mem_req && mem_gnt) begin
                if (dead_pending) begin
                    dead_pending = 1'b0;
                end else if (faulted) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_while_faulted: got grant at %h, expected none", mem_addr);
                end else begin
                    check("grant_addr", mem_addr, model_pc);
                    exp_q.push_back('{model_pc, mem_word(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
            end
            if (mem_req && mem_gnt) mq.push_back('{mem_addr, cyc + 1});
            prev_hold = mem_req && !mem_gnt;
            prev_addr = mem_addr;
        end
    end

    task automatic do_reset(input int g, input int rvp, input int rdy);
        @(negedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        exp_q.delete();
        model_pc = RESET_PC;
        dead_pending = 1'b0;
        faulted = 1'b0;
        gnt_mode = g;
        rv_pct = rvp;
        ready_pct = rdy;
        halt_pct = 0;
        redir_pm = 0;
        redir_req = 1'b0;
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_instr_pc", instr_pc, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_fetch_fault", fetch_fault, 0);
        check("rst_fault_pc", fault_pc, 0);
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int g;
        bit seen;

        // Streaming: grant every cycle, data one cycle later, decoder always ready.
        do_reset(0, 100, 100);
        @(negedge clock);
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, RESET_PC);
        n_pops = 0;
        repeat (20) @(negedge clock);
        check("stream_progress", 32'(n_pops >= 8), 1);

        // Decoder stalled: only QDEPTH reads may be granted.
        do_reset(0, 100, 0);
        g = 0;
        repeat (12) begin
            @(negedge clock);
            if (mem_req && mem_gnt) g++;
        end
        check("credit_grants", g, QDEPTH);
        check("credit_req_low", mem_req, 0);
        ready_pct = 100;
        repeat (10) @(negedge clock);

        // Grant withheld: request and address must hold.
        do_reset(2, 100, 100);
        repeat (5) begin
            @(negedge clock);
            check("nogrant_req", mem_req, 1);
            check("nogrant_addr", mem_addr, RESET_PC);
        end
        gnt_mode = 0;
        repeat (10) @(negedge clock);

        // Two reads in flight, then redirect to 0x100.
        do_reset(0, 0, 100);
        repeat (4) @(negedge clock);
        check("inflight_req_low", mem_req, 0);
        redir_target = 32'h0000_0100;
        redir_req = 1'b1;
        @(negedge clock);
        rv_pct = 100;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (instr_valid) seen = 1;
        end
        if (seen) check("redirect_first_pc", instr_pc, 32'h0000_0100);
        else check("redirect_timeout", 0, 1);
        repeat (10) @(negedge clock);

        // Redirect in the same cycle as a returning word.
        do_reset(0, 0, 0);
        repeat (4) @(negedge clock);
        rv_pct = 100;
        @(negedge clock);
        redir_target = 32'h0000_0200;
        redir_req = 1'b1;
        @(negedge clock);
        check("pre_redirect_valid", instr_valid, 1);
        @(negedge clock);
        check("redirect_rvalid_drop", instr_valid, 0);
        ready_pct = 100;
        repeat (20) @(negedge clock);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect faults and stops fetching until an aligned redirect.
        do_reset(0, 100, 100);
        repeat (6) @(negedge clock);
        redir_target = 32'h0000_0102;
        redir_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("fault_flag", fetch_fault, 1);
        check("fault_pc", fault_pc, 32'h0000_0102);
        repeat (6) @(negedge clock);
        check("fault_no_req", mem_req, 0);
        redir_target = 32'h0000_0300;
        redir_req = 1'b1;
        repeat (2) @(negedge clock);
        check("fault_cleared", fetch_fault, 0);
        repeat (10) @(negedge clock);
`endif

        // Random traffic, a reset in mid-flight, more random traffic.
        do_reset(1, 60, 70);
        halt_pct = 10;
        redir_pm = 30;
        repeat (1500) @(negedge clock);
        do_reset(1, 60, 70);
        halt_pct = 10;
        redir_pm = 30;
        repeat (1500) @(negedge clock);

        // Drain under halt: everything expected must come out, then no new requests.
        halt_pct = 100;
        redir_pm = 0;
        ready_pct = 100;
        rv_pct = 100;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && mq.size() == 0 && !mem_req && !instr_valid) seen = 1;
        end
        check("drain_left", 32'(exp_q.size()), 0);
        check("halt_no_req", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
